axis_out_framer: RTL

//  Frames the engine's output AXI-Stream into DMA transfers.
//  - Per command, passes exactly cmd_bpt bytes from s_* to m_*.
//  - Asserts m_last on the final beat of the transfer; partial final beats are masked via m_keep.
//  - Reports completion on a status handshake.

---
 rtl/axis_out_framer_if.sv | 52 +++++
 rtl/axis_out_framer.sv | 118 +++++++++++
 2 files changed

// File: rtl/axis_out_framer_if.sv
// Handshake bundle for axis_out_framer: command, input stream, output stream, status.
// No logic; slave modport is the framer's view, master modport is its environment's view.
// Widths are set by the instantiator and must match the framer's parameters.
interface axis_out_framer_if #(
  parameter int DW = 32,
  parameter int LW = 32,
  parameter int TW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [LW-1:0] cmd_bpt;
  logic [TW-1:0] cmd_tag;

  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;

  logic            m_valid;
  logic            m_ready;
  logic [DW-1:0]   m_data;
  logic [DW/8-1:0] m_keep;
  logic            m_last;

  logic [LW-1:0] cur_bpt;

  logic          sts_valid;
  logic          sts_ready;
  logic [TW-1:0] sts_tag;
  logic [LW-1:0] sts_bytes;

  modport slave (
    input  cmd_valid, cmd_bpt, cmd_tag,
    input  s_valid, s_data,
    input  m_ready,
    input  sts_ready,
    output cmd_ready, s_ready,
    output m_valid, m_data, m_keep, m_last,
    output cur_bpt,
    output sts_valid, sts_tag, sts_bytes
  );

  modport master (
    output cmd_valid, cmd_bpt, cmd_tag,
    output s_valid, s_data,
    output m_ready,
    output sts_ready,
    input  cmd_ready, s_ready,
    input  m_valid, m_data, m_keep, m_last,
    input  cur_bpt,
    input  sts_valid, sts_tag, sts_bytes
  );
endinterface

// File: rtl/axis_out_framer.sv
// Frames the output stream into cmd_bpt-byte transfers with m_last/m_keep, then reports status.
// Latency: 1 cycle s->m through a single output register; 1 beat/clk when m_ready is held high.
// Backpressure: s_ready follows output-register space (reload allowed while draining); stalls outside STREAM.
module axis_out_framer #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_LEN_WIDTH  = 32,
  parameter int AXI_TAG_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                rstn,
  axis_out_framer_if.slave    bus
);
  localparam int BPB = AXI_DATA_WIDTH / 8;
  localparam int LW  = AXI_LEN_WIDTH;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_STATUS = 2'd2;

  logic [1:0]                r_state;
  logic [LW-1:0]             r_rem;
  logic [LW-1:0]             r_bpt;
  logic [AXI_TAG_WIDTH-1:0]  r_tag;
  logic                      r_done_in;
  logic                      r_m_valid;
  logic [AXI_DATA_WIDTH-1:0] r_m_data;
  logic [BPB-1:0]            r_m_keep;
  logic                      r_m_last;

  logic           w_s_ready;
  logic           w_s_fire;
  logic           w_m_fire;
  logic           w_last;
  logic [LW-1:0]  w_take;
  logic [BPB-1:0] w_keep;

  // Keep, last flag and byte decrement for the beat that would be accepted now.
  always_comb begin
    w_last = (r_rem <= LW'(BPB));
    w_take = (r_rem < LW'(BPB)) ? r_rem : LW'(BPB);
    w_keep = '0;
    for (int b = 0; b < BPB; b++) begin
      w_keep[b] = (r_rem > LW'(b));
    end
  end

  // Accept input only while bytes remain and the output register is empty or draining.
  assign w_s_ready = (r_state == S_STREAM) && !r_done_in && (!r_m_valid || bus.m_ready);
  assign w_s_fire  = w_s_ready && bus.s_valid;
  assign w_m_fire  = r_m_valid && bus.m_ready;

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.s_ready   = w_s_ready;
  assign bus.m_valid   = r_m_valid;
  assign bus.m_data    = r_m_data;
  assign bus.m_keep    = r_m_keep;
  assign bus.m_last    = r_m_last;
  assign bus.cur_bpt   = (r_state == S_IDLE) ? '0 : r_bpt;
  assign bus.sts_valid = (r_state == S_STATUS);
  assign bus.sts_tag   = r_tag;
  assign bus.sts_bytes = r_bpt;

  // Transfer FSM: command latch, remaining-byte count and input-done tracking.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_rem     <= '0;
      r_bpt     <= '0;
      r_tag     <= '0;
      r_done_in <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_bpt     <= bus.cmd_bpt;
            r_tag     <= bus.cmd_tag;
            r_rem     <= bus.cmd_bpt;
            r_done_in <= 1'b0;
            r_state   <= (bus.cmd_bpt == '0) ? S_STATUS : S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_s_fire) begin
            r_rem <= r_rem - w_take;
            if (w_last) r_done_in <= 1'b1;
          end
          // The final beat leaving the register ends the data phase.
          if (w_m_fire && r_m_last) begin
            r_state   <= S_STATUS;
            r_done_in <= 1'b0;
          end
        end
        S_STATUS: begin
          if (bus.sts_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output register: load on accept (even while draining), otherwise clear once drained.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_keep  <= '0;
      r_m_last  <= 1'b0;
    end else if (w_s_fire) begin
      r_m_valid <= 1'b1;
      r_m_data  <= bus.s_data;
      r_m_keep  <= w_keep;
      r_m_last  <= w_last;
    end else if (w_m_fire) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end
  end
endmodule
